// File: rtl/shift_seq_pkg.sv
// rtl/shift_seq_pkg.sv - shared encodings and state type for the shift sequencer
// Contents:
//   OP_*    command op encodings carried on cmd_op
//   S_*     mode register select encodings driven on reg_s
//   state_t sequencer FSM states
//   is_shift() true for the multi-step ops (SHR/SHL)
package shift_seq_pkg;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_INV  = 2'b01;
    localparam logic [1:0] OP_SHR  = 2'b10;
    localparam logic [1:0] OP_SHL  = 2'b11;

    // The register's select encoding lines up with the op encoding, so an
    // op can be driven onto reg_s unchanged once the operand is loaded.
    localparam logic [1:0] S_PASS = 2'b00;
    localparam logic [1:0] S_INV  = 2'b01;
    localparam logic [1:0] S_SHR  = 2'b10;
    localparam logic [1:0] S_SHL  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_SHIFT = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    function automatic logic is_shift(input logic [1:0] op);
        return (op == OP_SHR) || (op == OP_SHL);
    endfunction

endpackage

// File: rtl/seq_down_counter.sv
// rtl/seq_down_counter.sv - loadable down counter holding remaining shift steps
// Ports:
//   clk       in   clock, rising edge
//   reset     in   synchronous, active-high; clears the count
//   load      in   capture load_val (wins over dec)
//   load_val  in   CNT_W value to capture
//   dec       in   decrement by one, saturating at zero
//   count     out  CNT_W current remaining count
//   zero      out  count == 0
module seq_down_counter #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             zero
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (dec && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign count = count_q;
    assign zero  = (count_q == '0);

endmodule

// File: rtl/shift_seq_ctrl.sv
// rtl/shift_seq_ctrl.sv - command sequencer driving a 4-bit mode register
// Ports:
//   clk        in   clock, all state on rising edge
//   reset      in   synchronous, active-high
//   cmd_valid  in   command present
//   cmd_ready  out  command accepted this cycle when valid (IDLE only)
//   cmd_op     in   2   LOAD / INVERT / SHR / SHL
//   cmd_data   in   WIDTH initial operand
//   cmd_count  in   CNT_W shift steps (SHR/SHL only)
//   reg_i      out  WIDTH register data input
//   reg_s      out  2   register mode select
//   reg_load   out  register load enable
//   reg_q      in   WIDTH register output, fed back during shifts
//   busy       out  high whenever not IDLE
//   done       out  one-cycle completion pulse
//   result     out  WIDTH register value, valid while done
module shift_seq_ctrl
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_count,
    output logic [WIDTH-1:0] reg_i,
    output logic [1:0]       reg_s,
    output logic             reg_load,
    input  logic [WIDTH-1:0] reg_q,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    state_t           state_q, state_d;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] data_q;
    logic             accept;
    logic             cnt_dec;
    logic [CNT_W-1:0] remaining;
    logic             cnt_zero;

    seq_down_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (accept),
        .load_val (cmd_count),
        .dec      (cnt_dec),
        .count    (remaining),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            op_q    <= OP_LOAD;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q   <= cmd_op;
                data_q <= cmd_data;
            end
        end
    end

    // Outputs are forced to their idle values while reset is high so that a
    // job in flight stops loading the register in the very cycle reset rises.
    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        accept    = 1'b0;
        cnt_dec   = 1'b0;
        reg_load  = 1'b0;
        reg_s     = S_PASS;
        reg_i     = '0;
        busy      = 1'b0;
        done      = 1'b0;
        if (!reset) begin
            case (state_q)
                ST_IDLE: begin
                    cmd_ready = 1'b1;
                    if (cmd_valid) begin
                        accept  = 1'b1;
                        state_d = ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    busy     = 1'b1;
                    reg_load = 1'b1;
                    reg_i    = data_q;
                    // Shift jobs first load the operand unchanged, then shift.
                    reg_s    = is_shift(op_q) ? S_PASS : op_q;
                    state_d  = (is_shift(op_q) && !cnt_zero) ? ST_SHIFT : ST_DONE;
                end
                ST_SHIFT: begin
                    busy     = 1'b1;
                    reg_load = 1'b1;
                    reg_i    = reg_q;
                    reg_s    = op_q;
                    cnt_dec  = 1'b1;
                    // Leave after the step that consumes the last remaining count.
                    state_d  = (remaining == CNT_W'(1)) ? ST_DONE : ST_SHIFT;
                end
                ST_DONE: begin
                    busy    = 1'b1;
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign result = reg_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb/tb_shift_seq_ctrl.sv - directed bench for shift_seq_ctrl with a looped-back 4-bit mode register
module tb_shift_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic [3:0] cmd_data = 4'b0;
    logic [2:0] cmd_count = 3'b0;
    logic [3:0] reg_i;
    logic [1:0] reg_s;
    logic       reg_load;
    logic [3:0] reg_q = 4'b0;
    logic       busy;
    logic       done;
    logic [3:0] result;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    logic [1:0] s_seq [0:31];
    int s_len;

    always #5 clk = ~clk;

    shift_seq_ctrl #(.WIDTH(4), .CNT_W(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_count (cmd_count),
        .reg_i     (reg_i),
        .reg_s     (reg_s),
        .reg_load  (reg_load),
        .reg_q     (reg_q),
        .busy      (busy),
        .done      (done),
        .result    (result)
    );

    // Behavioural 4-bit mode register: 00 pass, 01 invert, 10 shr, 11 shl, zero fill.
    always @(posedge clk) begin
        if (reg_load) begin
            case (reg_s)
                2'b00: reg_q <= reg_i;
                2'b01: reg_q <= ~reg_i;
                2'b10: reg_q <= reg_i >> 1;
                2'b11: reg_q <= reg_i << 1;
                default: reg_q <= reg_q;
            endcase
        end
    end

    always @(posedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
    end

    // Presents a command at a falling edge and returns one falling edge after
    // acceptance, i.e. in the LOAD cycle (relative cycle 1).
    task automatic send_cmd(input logic [1:0] op, input logic [3:0] data, input logic [2:0] cnt);
        int n;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        cmd_count = cnt;
        n = 0;
        while (!cmd_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: cmd_ready=%b required 1", cmd_ready);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Called in relative cycle 1; returns the relative cycle of done and the result.
    task automatic wait_done(output int lat, output logic [3:0] res);
        lat = 1;
        s_len = 0;
        while (!done && lat < 30) begin
            if (reg_load) begin
                s_seq[s_len] = reg_s;
                s_len++;
            end
            @(negedge clk);
            lat++;
        end
        if (!done) lat = -1;
        res = result;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({cmd_ready, busy, done, reg_load} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: ready/busy/done/load=%b required 0000", {cmd_ready, busy, done, reg_load});
        end
        checks++;
        if ({reg_s, reg_i} !== 6'b0) begin
            errors++;
            $display("FAIL reset_regio: s/i=%b required 000000", {reg_s, reg_i});
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: ready=%b busy=%b required 1 0", cmd_ready, busy);
        end
    endtask

    task automatic test_shl2;
        int lat;
        logic [3:0] res;
        send_cmd(2'b11, 4'b0011, 3'd2);
        checks++;
        if (reg_i !== 4'b0011 || busy !== 1'b1) begin
            errors++;
            $display("FAIL shl2_load: reg_i=%b busy=%b required 0011 1", reg_i, busy);
        end
        wait_done(lat, res);
        checks++;
        if (lat !== 4 || res !== 4'b1100) begin
            errors++;
            $display("FAIL shl2: lat=%0d res=%b required 4 1100", lat, res);
        end
        checks++;
        if (s_len !== 3 || s_seq[0] !== 2'b00 || s_seq[1] !== 2'b11 || s_seq[2] !== 2'b11) begin
            errors++;
            $display("FAIL shl2_sseq: len=%0d s=%b,%b,%b required 3 00,11,11", s_len, s_seq[0], s_seq[1], s_seq[2]);
        end
        checks++;
        if (busy !== 1'b1 || reg_load !== 1'b0) begin
            errors++;
            $display("FAIL shl2_done_state: busy=%b load=%b required 1 0", busy, reg_load);
        end
    endtask

    task automatic test_shr1;
        int lat;
        logic [3:0] res;
        send_cmd(2'b10, 4'b1001, 3'd1);
        wait_done(lat, res);
        checks++;
        if (lat !== 3 || res !== 4'b0100) begin
            errors++;
            $display("FAIL shr1: lat=%0d res=%b required 3 0100", lat, res);
        end
    endtask

    task automatic test_inv_load;
        int lat;
        logic [3:0] res;
        send_cmd(2'b01, 4'b1010, 3'd5);
        wait_done(lat, res);
        checks++;
        if (lat !== 2 || res !== 4'b0101) begin
            errors++;
            $display("FAIL invert: lat=%0d res=%b required 2 0101", lat, res);
        end
        send_cmd(2'b00, 4'b0110, 3'd3);
        wait_done(lat, res);
        checks++;
        if (lat !== 2 || res !== 4'b0110) begin
            errors++;
            $display("FAIL load: lat=%0d res=%b required 2 0110", lat, res);
        end
    endtask

    task automatic test_count_bounds;
        int lat;
        logic [3:0] res;
        send_cmd(2'b11, 4'b0001, 3'd7);
        wait_done(lat, res);
        checks++;
        if (lat !== 9 || res !== 4'b0000) begin
            errors++;
            $display("FAIL shl7: lat=%0d res=%b required 9 0000", lat, res);
        end
        send_cmd(2'b10, 4'b1011, 3'd0);
        wait_done(lat, res);
        checks++;
        if (lat !== 2 || res !== 4'b1011) begin
            errors++;
            $display("FAIL shr0: lat=%0d res=%b required 2 1011", lat, res);
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        int d0;
        logic [3:0] res;
        @(negedge clk);
        d0 = done_cnt;
        cmd_valid = 1'b1;
        cmd_op    = 2'b11;
        cmd_data  = 4'b0011;
        cmd_count = 3'd1;
        @(negedge clk);
        // First command taken; queue the second with valid held high.
        cmd_op    = 2'b01;
        cmd_data  = 4'b1100;
        cmd_count = 3'd0;
        for (int r = 1; r <= 3; r++) begin
            checks++;
            if (cmd_ready !== 1'b0) begin
                errors++;
                $display("FAIL b2b_ready_busy: rel=%0d ready=%b required 0", r, cmd_ready);
            end
            if (r < 3) @(negedge clk);
        end
        checks++;
        if (done !== 1'b1 || result !== 4'b0110) begin
            errors++;
            $display("FAIL b2b_first: done=%b res=%b required 1 0110", done, result);
        end
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_reaccept: ready=%b busy=%b required 1 0", cmd_ready, busy);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_done(lat, res);
        checks++;
        if (lat !== 2 || res !== 4'b0011) begin
            errors++;
            $display("FAIL b2b_second: lat=%0d res=%b required 2 0011", lat, res);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (done_cnt - d0 !== 2 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_count: dones=%0d busy=%b required 2 0", done_cnt - d0, busy);
        end
    endtask

    task automatic test_reset_mid_job;
        int lat;
        int d0;
        logic [3:0] res;
        send_cmd(2'b11, 4'b0001, 3'd5);
        d0 = done_cnt;
        repeat (2) @(negedge clk);
        // Now in the second SHIFT cycle.
        checks++;
        if (reg_load !== 1'b1 || reg_s !== 2'b11) begin
            errors++;
            $display("FAIL mid_pre: load=%b s=%b required 1 11", reg_load, reg_s);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (reg_load !== 1'b0 || cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_same_cycle: load=%b ready=%b required 0 0", reg_load, cmd_ready);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || reg_load !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_after: busy=%b done=%b load=%b ready=%b required 0 0 0 1", busy, done, reg_load, cmd_ready);
        end
        repeat (8) @(negedge clk);
        checks++;
        if (done_cnt !== d0) begin
            errors++;
            $display("FAIL mid_no_done: dones=%0d required %0d", done_cnt, d0);
        end
        send_cmd(2'b10, 4'b1000, 3'd2);
        wait_done(lat, res);
        checks++;
        if (lat !== 4 || res !== 4'b0010) begin
            errors++;
            $display("FAIL mid_fresh: lat=%0d res=%b required 4 0010", lat, res);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        test_shl2;
        test_shr1;
        test_inv_load;
        test_count_bounds;
        test_back_to_back;
        test_reset_mid_job;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
